// File: rtl/audio_pkg.sv
// Shared audio constants: sample width, clock-divider taps and the
// I2S slot layout, plus the slot-to-bit select helper.
package audio_pkg;

    localparam int AUDIO_W         = 16;
    localparam int MCLK_BIT        = 1;
    localparam int SCK_BIT         = 3;
    localparam int LRCK_BIT        = 9;
    localparam int CNT_W           = LRCK_BIT + 1;
    localparam int FRAME_LEN       = 1024;
    localparam int DATA_START_SLOT = 1;
    localparam int SLOTS_PER_HALF  = 32;
    localparam int SLOT_W          = 5;

    localparam logic [SLOT_W-1:0] DATA_FIRST =
        SLOT_W'(DATA_START_SLOT);
    localparam logic [SLOT_W-1:0] DATA_LAST  =
        SLOT_W'(DATA_START_SLOT + AUDIO_W - 1);
    localparam logic [3:0]        MSB_IDX    = 4'(AUDIO_W - 1);

    // Bit carried by a given slot: MSB first starting at the
    // data start slot, zero in the delay slot and the pad slots.
    function automatic logic slot_bit(
        input logic [AUDIO_W-1:0] w,
        input logic [SLOT_W-1:0]  s
    );
        logic [SLOT_W-1:0] off;
        slot_bit = 1'b0;
        off      = s - DATA_FIRST;
        if (s >= DATA_FIRST && s <= DATA_LAST) begin
            slot_bit = w[MSB_IDX - off[3:0]];
        end
    endfunction

endpackage

// File: rtl/i2s_speaker_tx_if.sv
// Sample source <-> I2S transmitter bundle and DAC pins.
// master: sample source / board; slave: the transmitter.
import audio_pkg::*;

interface i2s_speaker_tx_if;

    logic [AUDIO_W-1:0] audio_left;
    logic [AUDIO_W-1:0] audio_right;
    logic               mute;
    logic               audio_mclk;
    logic               audio_lrck;
    logic               audio_sck;
    logic               audio_sdin;
    logic               sample_req;

    modport master (
        output audio_left,
        output audio_right,
        output mute,
        input  audio_mclk,
        input  audio_lrck,
        input  audio_sck,
        input  audio_sdin,
        input  sample_req
    );

    modport slave (
        input  audio_left,
        input  audio_right,
        input  mute,
        output audio_mclk,
        output audio_lrck,
        output audio_sck,
        output audio_sdin,
        output sample_req
    );

endinterface

// File: rtl/i2s_clk_gen.sv
// Free-running frame counter: mclk/sck/lrck taps, capture and bit-edge
// strobes, and the slot/half that starts on the next clock edge.
// Ports: clk, rst (async low) in; *_o taps and strobes out.
import audio_pkg::*;

module i2s_clk_gen (
    input  logic              clk,
    input  logic              rst,
    output logic              mclk_o,
    output logic              sck_o,
    output logic              lrck_o,
    output logic              capture_o,
    output logic              bit_edge_o,
    output logic [SLOT_W-1:0] slot_o,
    output logic              half_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign cnt_d = cnt_q + CNT_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign mclk_o     = cnt_q[MCLK_BIT];
    assign sck_o      = cnt_q[SCK_BIT];
    assign lrck_o     = cnt_q[LRCK_BIT];
    assign capture_o  = &cnt_q;
    assign bit_edge_o = &cnt_q[SCK_BIT:0];

    // sdin is loaded one clock ahead, so it needs the upcoming slot.
    assign slot_o = cnt_d[LRCK_BIT-1:SCK_BIT+1];
    assign half_o = cnt_d[LRCK_BIT];

endmodule

// File: rtl/i2s_speaker_tx.sv
// Stereo I2S transmitter: captures both channels once per frame and
// shifts them out MSB first. Ports: clk, rst (async low), bus (slave).
import audio_pkg::*;

module i2s_speaker_tx (
    input  logic             clk,
    input  logic             rst,
    i2s_speaker_tx_if.slave  bus
);

    logic              capture;
    logic              bit_edge;
    logic [SLOT_W-1:0] nslot;
    logic              nhalf;

    logic [AUDIO_W-1:0] hold_l_q, hold_l_d;
    logic [AUDIO_W-1:0] hold_r_q, hold_r_d;
    logic               sdin_q,   sdin_d;

    i2s_clk_gen u_clk_gen (
        .clk        (clk),
        .rst        (rst),
        .mclk_o     (bus.audio_mclk),
        .sck_o      (bus.audio_sck),
        .lrck_o     (bus.audio_lrck),
        .capture_o  (capture),
        .bit_edge_o (bit_edge),
        .slot_o     (nslot),
        .half_o     (nhalf)
    );

    always_comb begin
        hold_l_d = hold_l_q;
        hold_r_d = hold_r_q;
        sdin_d   = sdin_q;
        if (capture) begin
            hold_l_d = bus.mute ? '0 : bus.audio_left;
            hold_r_d = bus.mute ? '0 : bus.audio_right;
        end
        // On the capture edge the next slot is the left delay slot,
        // so reading the old hold registers here is harmless.
        if (bit_edge) begin
            sdin_d = slot_bit(nhalf ? hold_r_q : hold_l_q, nslot);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_l_q <= '0;
            hold_r_q <= '0;
            sdin_q   <= 1'b0;
        end else begin
            hold_l_q <= hold_l_d;
            hold_r_q <= hold_r_d;
            sdin_q   <= sdin_d;
        end
    end

    assign bus.audio_sdin = sdin_q;
    assign bus.sample_req = capture;

endmodule

// File: tb/tb_i2s_speaker_tx.sv
// Self-checking bench for i2s_speaker_tx: frame timing, decoded words,
// mid-frame input changes, mute, mid-frame reset, random samples.
module tb_i2s_speaker_tx;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    i2s_speaker_tx_if bus ();

    i2s_speaker_tx dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Leaves the bench at the negedge where sample_req is high (cnt=1023).
    task automatic wait_req();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 2100; i++) begin
            @(negedge clk);
            if (bus.sample_req) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL sync: no sample_req within 2100 clk");
        end
    endtask

    // Observes one frame starting at cnt=0; samples sdin mid-slot.
    task automatic decode_frame(
        input  int          chg_at,
        input  logic [15:0] chg_val,
        output logic [15:0] l,
        output logic [15:0] r,
        output logic        pad
    );
        logic b [0:1][0:31];
        for (int i = 0; i < 1024; i++) begin
            @(negedge clk);
            if (i == chg_at) bus.audio_left = chg_val;
            if (i % 16 == 8) b[i / 512][(i % 512) / 16] = bus.audio_sdin;
        end
        pad = 1'b0;
        for (int h = 0; h < 2; h++) begin
            for (int s = 0; s < 32; s++) begin
                if (s == 0 || s > 16) pad = pad | b[h][s];
            end
        end
        for (int s = 1; s <= 16; s++) begin
            l[16 - s] = b[0][s];
            r[16 - s] = b[1][s];
        end
    endtask

    task automatic test_reset();
        int n;
        bus.audio_left  = 16'hFFFF;
        bus.audio_right = 16'hFFFF;
        bus.mute        = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.audio_mclk, bus.audio_sck, bus.audio_lrck,
                 bus.audio_sdin, bus.sample_req} !== 5'b0) begin
                errors++;
                $display("FAIL reset_outputs: cyc=%0d got=%b want=00000", i,
                         {bus.audio_mclk, bus.audio_sck, bus.audio_lrck,
                          bus.audio_sdin, bus.sample_req});
            end
        end
        @(posedge clk);
        #1 rst = 1'b1;
        n = 0;
        for (int i = 0; i < 2100; i++) begin
            @(negedge clk);
            n++;
            if (bus.sample_req) break;
        end
        checks++;
        if (n !== 1024) begin
            errors++;
            $display("FAIL first_req: got clk %0d want clk 1024", n);
        end
    endtask

    task automatic test_free_run();
        logic [15:0] lv, rv, w;
        logic [4:0]  got, exp;
        int          last, s, c;
        lv = 16'($urandom);
        rv = 16'($urandom);
        bus.audio_left  = lv;
        bus.audio_right = rv;
        bus.mute        = 1'b0;
        wait_req();
        last = -1;
        for (int k = 0; k < 4096; k++) begin
            @(negedge clk);
            c = k % 1024;
            s = (c % 512) / 16;
            w = (c >= 512) ? rv : lv;
            exp[4] = 1'((c / 2) % 2);
            exp[3] = 1'((c / 8) % 2);
            exp[2] = 1'(c / 512);
            exp[1] = (c == 1023);
            exp[0] = (s >= 1 && s <= 16) ? w[16 - s] : 1'b0;
            got = {bus.audio_mclk, bus.audio_sck, bus.audio_lrck,
                   bus.sample_req, bus.audio_sdin};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL free_run: cnt=%0d got=%b want=%b", c, got, exp);
            end
            if (bus.sample_req === 1'b1) begin
                if (last >= 0) begin
                    checks++;
                    if (k - last !== 1024) begin
                        errors++;
                        $display("FAIL req_period: got %0d want 1024", k - last);
                    end
                end
                last = k;
            end
        end
    endtask

    task automatic test_pattern();
        logic [15:0] l, r;
        logic        pad;
        bus.audio_left  = 16'hEEE0;
        bus.audio_right = 16'h0020;
        wait_req();
        decode_frame(-1, 16'h0, l, r, pad);
        checks++;
        if (l !== 16'hEEE0) begin
            errors++;
            $display("FAIL pattern_left: got %h want eee0", l);
        end
        checks++;
        if (r !== 16'h0020) begin
            errors++;
            $display("FAIL pattern_right: got %h want 0020", r);
        end
        checks++;
        if (pad !== 1'b0) begin
            errors++;
            $display("FAIL pattern_pad: got %b want 0", pad);
        end
    endtask

    task automatic test_midframe_change();
        logic [15:0] l, r;
        logic        pad;
        bus.audio_left = 16'hEEE0;
        wait_req();
        decode_frame(300, 16'h1234, l, r, pad);
        checks++;
        if (l !== 16'hEEE0) begin
            errors++;
            $display("FAIL midframe_cur: got %h want eee0", l);
        end
        decode_frame(-1, 16'h0, l, r, pad);
        checks++;
        if (l !== 16'h1234) begin
            errors++;
            $display("FAIL midframe_next: got %h want 1234", l);
        end
    endtask

    task automatic test_mute();
        logic [15:0] l, r;
        logic        pad;
        bus.audio_left  = 16'hEEE0;
        bus.audio_right = 16'h0020;
        bus.mute        = 1'b1;
        wait_req();
        bus.mute = 1'b0;
        bus.mute = 1'b1;
        decode_frame(-1, 16'h0, l, r, pad);
        checks++;
        if ({l, r} !== 32'h0) begin
            errors++;
            $display("FAIL mute_on: got %h_%h want 0000_0000", l, r);
        end
        bus.mute = 1'b0;
        decode_frame(-1, 16'h0, l, r, pad);
        checks++;
        if ({l, r} !== 32'hEEE0_0020) begin
            errors++;
            $display("FAIL mute_off: got %h_%h want eee0_0020", l, r);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] l, r;
        logic        pad;
        logic [4:0]  got;
        bus.audio_left  = 16'hEEE0;
        bus.audio_right = 16'hFFFF;
        wait_req();
        for (int i = 0; i <= 600; i++) @(negedge clk);
        checks++;
        if ({bus.audio_lrck, bus.audio_sck, bus.audio_sdin} !== 3'b111) begin
            errors++;
            $display("FAIL pre_reset: lrck/sck/sdin got %b want 111",
                     {bus.audio_lrck, bus.audio_sck, bus.audio_sdin});
        end
        #2 rst = 1'b0;
        #1;
        got = {bus.audio_mclk, bus.audio_sck, bus.audio_lrck,
               bus.audio_sdin, bus.sample_req};
        checks++;
        if (got !== 5'b0) begin
            errors++;
            $display("FAIL reset_mid: got %b want 00000", got);
        end
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        decode_frame(-1, 16'h0, l, r, pad);
        checks++;
        if ({l, r, pad} !== 33'h0) begin
            errors++;
            $display("FAIL post_reset_zero: got %h_%h pad=%b want 0000_0000 pad=0",
                     l, r, pad);
        end
        checks++;
        if (bus.sample_req !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_req: got %b want 1", bus.sample_req);
        end
        decode_frame(-1, 16'h0, l, r, pad);
        checks++;
        if ({l, r} !== 32'hEEE0_FFFF) begin
            errors++;
            $display("FAIL post_reset_data: got %h_%h want eee0_ffff", l, r);
        end
    endtask

    task automatic test_random();
        logic [15:0] a, b, l, r, el, er;
        logic        m, pad;
        wait_req();
        for (int it = 0; it < 5; it++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            m = ($urandom_range(0, 2) == 0);
            bus.audio_left  = a;
            bus.audio_right = b;
            bus.mute        = m;
            el = m ? 16'h0 : a;
            er = m ? 16'h0 : b;
            decode_frame(int'($urandom_range(1, 1000)), 16'($urandom),
                         l, r, pad);
            checks++;
            if ({l, r, pad} !== {el, er, 1'b0}) begin
                errors++;
                $display("FAIL random[%0d]: got %h_%h pad=%b want %h_%h pad=0",
                         it, l, r, pad, el, er);
            end
        end
        bus.mute = 1'b0;
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_pattern();
        test_midframe_change();
        test_mute();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
